// File: rtl/coeff_buffer_loader_pkg.sv
// saber_buf_pkg: shared widths and slot-size helpers for the coefficient buffer loader.
package saber_buf_pkg;
  localparam int WORD_W = 64;
  localparam int COEFF_W = 13;
  localparam int TEN_LANE_W = 16;
  localparam int NUM_SLOTS = 13;
  localparam int NUM_TEN_SLOTS = 2;
  function automatic int cw(input int m);
    return COEFF_W * (m + 1);
  endfunction
  function automatic int tw(input int m);
    return TEN_LANE_W * (m + 1);
  endfunction
  // Sized for the wider ten-bit slot: a word may land on up to TW-1 residue bits.
  function automatic int acc_w(input int m);
    return WORD_W + tw(m) - 1;
  endfunction
  function automatic int cnt_w(input int m);
    return $clog2(WORD_W + tw(m));
  endfunction
endpackage

// File: rtl/coeff_buffer_loader_if.sv
// coeff_buffer_loader_if: valid/ready packed-word stream from the polynomial BRAM reader.
interface coeff_buffer_loader_if;
  logic [saber_buf_pkg::WORD_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  modport master(output in_data, output in_valid, input in_ready);
  modport slave(input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/coeff_buffer_loader_accum.sv
// loader_bit_accum: LSB-first bit accumulator with 64-bit append and slot-width pop.
module loader_bit_accum
  import saber_buf_pkg::*;
#(
  parameter int MULTIPLIERS = 1,
  localparam int CW = cw(MULTIPLIERS),
  localparam int TW = tw(MULTIPLIERS),
  localparam int AW = acc_w(MULTIPLIERS),
  localparam int NW = cnt_w(MULTIPLIERS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] word,
  input  logic              pop,
  input  logic              ten,
  output logic [TW-1:0]     head,
  output logic [NW-1:0]     acc_cnt
);
  logic [AW-1:0] acc;
  assign head = acc[TW-1:0];
  // Bits above acc_cnt are kept zero so an append can simply OR in.
  always_ff @(posedge clk)
    if (rst || clear) begin
      acc <= '0;
      acc_cnt <= '0;
    end else if (push) begin
      acc <= acc | (AW'(word) << acc_cnt);
      acc_cnt <= acc_cnt + NW'(WORD_W);
    end else if (pop) begin
      acc <= ten ? acc >> TW : acc >> CW;
      acc_cnt <= acc_cnt - (ten ? NW'(TW) : NW'(CW));
    end
endmodule

// File: rtl/coeff_buffer_loader.sv
// coeff_buffer_loader: unpacks packed words into coefficient slots; COEFF_BUFFER_LOADER_ERR_EN adds sticky err.
module coeff_buffer_loader
  import saber_buf_pkg::*;
#(
  parameter int MULTIPLIERS = 1,
  localparam int CW = cw(MULTIPLIERS),
  localparam int TW = tw(MULTIPLIERS),
  localparam int NW = cnt_w(MULTIPLIERS)
) (
  input  logic                        clk,
  input  logic                        rst,
  coeff_buffer_loader_if.slave        feed,
  input  logic                        ten_bit_coeff,
  input  logic                        consume,
  input  logic                        flush,
  output logic [NUM_SLOTS*CW-1:0]     slots_out,
  output logic [NUM_TEN_SLOTS*TW-1:0] ten_slots_out,
  output logic                        full,
  output logic [3:0]                  slot_count,
  output logic                        mode_q
`ifdef COEFF_BUFFER_LOADER_ERR_EN
  ,
  output logic                        err
`endif
);
  logic [CW-1:0] slots [NUM_SLOTS];
  logic [TW-1:0] ten_slots [NUM_TEN_SLOTS];
  logic [TW-1:0] head;
  logic [NW-1:0] acc_cnt;
  logic [NW-1:0] sw;
  logic [3:0] last;
  logic accept;
  logic extract;
  always_comb begin
    sw = mode_q ? NW'(TW) : NW'(CW);
    last = mode_q ? 4'(NUM_TEN_SLOTS - 1) : 4'(NUM_SLOTS - 1);
    extract = !full && !flush && acc_cnt >= sw;
    accept = feed.in_valid && feed.in_ready;
  end
  // A flush cycle drops any offered word, so ready is withheld there.
  assign feed.in_ready = !rst && !full && !flush && acc_cnt < sw;
  loader_bit_accum #(.MULTIPLIERS(MULTIPLIERS)) u_accum (
    .clk(clk),
    .rst(rst),
    .clear(flush),
    .push(accept),
    .word(feed.in_data),
    .pop(extract),
    .ten(mode_q),
    .head(head),
    .acc_cnt(acc_cnt)
  );
  always_ff @(posedge clk)
    if (rst) begin
      slot_count <= '0;
      full <= 1'b0;
      mode_q <= 1'b0;
    end else begin
      if (!extract && slot_count == '0) mode_q <= ten_bit_coeff;
      if (flush || (consume && full)) begin
        slot_count <= '0;
        full <= 1'b0;
      end else if (extract) begin
        slot_count <= slot_count + 4'd1;
        full <= slot_count == last;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
      for (int i = 0; i < NUM_TEN_SLOTS; i++) ten_slots[i] <= '0;
    end else if (extract) begin
      if (mode_q) ten_slots[slot_count[0]] <= head;
      else slots[slot_count] <= head[CW-1:0];
    end
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
    assign slots_out[k*CW +: CW] = slots[k];
  end
  for (genvar k = 0; k < NUM_TEN_SLOTS; k++) begin : g_ten
    assign ten_slots_out[k*TW +: TW] = ten_slots[k];
  end
`ifdef COEFF_BUFFER_LOADER_ERR_EN
  always_ff @(posedge clk)
    if (rst) err <= 1'b0;
    else if ((consume && !full) || (flush && feed.in_valid)) err <= 1'b1;
`endif
endmodule
